// File: rtl/cic_tx_feeder_if.sv
// Host-write and CIC-sample signals of the transmit feeder.
// The master side drives the phase, requests and writes; the slave is the feeder.
interface cic_tx_feeder_if #(
  parameter int DW = 18,
  parameter int AW = 4
) ();
  logic          ce;
  logic          tie;
  logic [DW-1:0] tdi;
  logic          wr;
  logic [DW-1:0] wx;
  logic [DW-1:0] wy;
  logic          full;
  logic [AW:0]   level;

  modport master (output ce, tie, wr, wx, wy, input tdi, full, level);
  modport slave  (input ce, tie, wr, wx, wy, output tdi, full, level);
endinterface

// File: rtl/cic_tx_feeder.sv
// Pair FIFO feeding the dual-channel CIC interpolator: X on ce=0, Y on ce=1.
// It primes before running, substitutes zeros on underflow, and keeps sticky urun/ovr flags.
module cic_tx_feeder #(
  parameter int DW    = 18,
  parameter int AW    = 4,
  parameter int PRIME = 8
) (
  input  logic             dclk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic             run,
  output logic             urun,
  output logic             ovr,
  cic_tx_feeder_if.slave   bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t          st, st_nxt;
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     lvl, lvl_nxt;
  logic            full_r;
  logic [DW-1:0]   hx, hy;
  logic [2*DW-1:0] mem [DEPTH];
  logic            flush, empty, rd, rd_ok, wr_ok, uflow, oflow;

  always_ff @(posedge dclk) begin
    if (!rstn) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (en) st_nxt = S_PRIME;
      S_PRIME: if (!en) st_nxt = S_IDLE;
               else if (lvl >= (AW+1)'(PRIME)) st_nxt = S_RUN;
      S_RUN:   if (!en) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Dropping en flushes on the same edge that the state returns to IDLE.
  always_comb begin
    run   = (st == S_RUN);
    flush = (st == S_IDLE) || !en;
    empty = (lvl == '0);
    rd    = !flush && (st == S_RUN) && bus.tie && bus.ce;
    rd_ok = rd && !empty;
    uflow = rd && empty;
    wr_ok = !flush && bus.wr && !full_r;
    oflow = !flush && bus.wr && full_r;
  end

  always_comb begin
    lvl_nxt = lvl;
    case ({wr_ok, rd_ok})
      2'b10:   lvl_nxt = lvl + (AW+1)'(1);
      2'b01:   lvl_nxt = lvl - (AW+1)'(1);
      default: lvl_nxt = lvl;
    endcase
  end

  // Distributed storage: asynchronous read of the head entry, no reset needed.
  always_ff @(posedge dclk) begin
    if (wr_ok) mem[wptr] <= {bus.wx, bus.wy};
  end

  always_ff @(posedge dclk) begin
    if (!rstn) begin
      wptr   <= '0;
      rptr   <= '0;
      lvl    <= '0;
      full_r <= 1'b0;
      hx     <= '0;
      hy     <= '0;
      urun   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (flush) begin
        wptr   <= '0;
        rptr   <= '0;
        lvl    <= '0;
        full_r <= 1'b0;
        hx     <= '0;
        hy     <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + AW'(1);
        if (rd_ok) rptr <= rptr + AW'(1);
        if (rd)    {hx, hy} <= empty ? '0 : mem[rptr];
        lvl    <= lvl_nxt;
        full_r <= (lvl_nxt == (AW+1)'(DEPTH));
      end
      // A set event on the same edge as clr wins.
      urun <= (urun & ~clr) | uflow;
      ovr  <= (ovr  & ~clr) | oflow;
    end
  end

  assign bus.tdi   = bus.ce ? hy : hx;
  assign bus.full  = full_r;
  assign bus.level = lvl;
endmodule

// File: tb/tb_cic_tx_feeder.sv
// Directed bench for cic_tx_feeder with a queue scoreboard of expected pairs.
module tb_cic_tx_feeder;
  localparam int DW = 18, AW = 4, PRIME = 8, DEPTH = 16;

  logic dclk = 1'b0, rstn = 1'b0, en = 1'b0, clr = 1'b0;
  logic run, urun, ovr;

  cic_tx_feeder_if #(.DW(DW), .AW(AW)) bus ();

  cic_tx_feeder #(.DW(DW), .AW(AW), .PRIME(PRIME)) dut (
    .dclk(dclk), .rstn(rstn), .en(en), .clr(clr),
    .run(run), .urun(urun), .ovr(ovr), .bus(bus.slave)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0, n_err = 0;
  logic [2*DW-1:0] q[$];
  int m_st = 0;
  logic [DW-1:0] ehx = '0, ehy = '0;
  logic m_urun = 1'b0, m_ovr = 1'b0;
  int nrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One dclk: apply inputs, advance the model, then check every output.
  task automatic cyc(input logic w, input int x, input int y, input logic t, input logic c);
    logic fl, rdv, us, os;
    logic [DW-1:0] xv, yv;
    int sz, nst;
    xv = DW'(x); yv = DW'(y);
    bus.wr = w; bus.wx = xv; bus.wy = yv; bus.tie = t; clr = c;
    sz = q.size();
    nst = m_st;
    if (!rstn) begin
      q.delete(); m_st = 0; ehx = '0; ehy = '0; m_urun = 1'b0; m_ovr = 1'b0;
    end else begin
      fl  = (m_st == 0) || !en;
      rdv = !fl && (m_st == 2) && t && bus.ce;
      us  = rdv && (sz == 0);
      os  = !fl && w && (sz == DEPTH);
      if (fl) begin
        q.delete(); ehx = '0; ehy = '0;
      end else begin
        if (rdv) begin
          if (sz == 0) begin ehx = '0; ehy = '0; end
          else {ehx, ehy} = q.pop_front();
        end
        if (w && sz < DEPTH) q.push_back({xv, yv});
      end
      m_urun = (m_urun & ~c) | us;
      m_ovr  = (m_ovr  & ~c) | os;
      case (m_st)
        0: if (en) nst = 1;
        1: if (!en) nst = 0; else if (sz >= PRIME) nst = 2;
        default: if (!en) nst = 0;
      endcase
      m_st = nst;
    end
    @(posedge dclk);
    #1 bus.ce = ~bus.ce;
    #1;
    chk("tdi",   bus.tdi,   bus.ce ? ehy : ehx);
    chk("level", bus.level, q.size());
    chk("full",  bus.full,  q.size() == DEPTH);
    chk("run",   run,       m_st == 2);
    chk("urun",  urun,      m_urun);
    chk("ovr",   ovr,       m_ovr);
    bus.wr = 1'b0; bus.tie = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Request lands on a ce=1 edge; optional write and clr on the same edge.
  task automatic req(input logic w, input int x, input int y, input logic c);
    if (bus.ce == 1'b0) idle(1);
    cyc(w, x, y, 1'b1, c);
  endtask

  task automatic restart();
    en = 1'b0; idle(1);
    en = 1'b1; idle(1);
  endtask

  initial begin
    bus.ce = 1'b0; bus.tie = 1'b0; bus.wr = 1'b0; bus.wx = '0; bus.wy = '0;

    // Reset, then prime with a constant pair.
    rstn = 1'b0; idle(4);
    rstn = 1'b1; en = 1'b1; idle(1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 100000, -100000, 1'b0, 1'b0);
    idle(3);
    req(1'b0, 0, 0, 1'b0);
    idle(4);

    // Streaming: 16 pairs, one request every 16 dclk.
    restart();
    nrd = 0;
    for (int i = 0; i < 16 * 18; i++) begin
      logic t;
      t = bus.ce && (i % 16 >= 14) && (nrd < 16);
      if (t) nrd++;
      cyc(i < 16, i + 1, -(i + 1), t, 1'b0);
    end
    idle(2);

    // Underflow: prime 8, read 10, then recover with (5,-5).
    restart();
    for (int i = 0; i < 8; i++) cyc(1'b1, 30 + i, -(30 + i), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 10; i++) req(1'b0, 0, 0, 1'b0);
    idle(1);
    cyc(1'b1, 5, -5, 1'b0, 1'b0);
    req(1'b0, 0, 0, 1'b0);
    idle(2);

    // Clear racing a new underflow keeps urun; clr alone clears both.
    req(1'b0, 0, 0, 1'b1);
    idle(1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1);

    // Overflow: 17 writes, then write+read while full, then drain.
    restart();
    for (int i = 0; i < 17; i++) cyc(1'b1, 200 + i, -(200 + i), 1'b0, 1'b0);
    req(1'b1, 999, -999, 1'b0);
    for (int i = 0; i < 15; i++) req(1'b0, 0, 0, 1'b0);
    idle(2);
    cyc(1'b0, 0, 0, 1'b0, 1'b1);

    // Disable mid-run at level 6; writes while disabled are ignored.
    restart();
    for (int i = 0; i < 8; i++) cyc(1'b1, 70 + i, -(70 + i), 1'b0, 1'b0);
    idle(2);
    req(1'b0, 0, 0, 1'b0);
    req(1'b0, 0, 0, 1'b0);
    en = 1'b0; idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1, -1, 1'b0, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
